// File: rtl/cache_ctrl_pkg.sv
// Shared types and field widths for the direct-mapped cache miss controller.
package cache_ctrl_pkg;

  localparam int TAG_W  = 5;
  localparam int IDX_W  = 8;
  localparam int OFF_W  = 3;
  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WB    = 2'd1,
    FILL  = 2'd2,
    RETRY = 2'd3
  } state_t;

  // Byte address of word w within the line {tag, idx}.
  function automatic logic [WORD_W-1:0] word_addr(input logic [TAG_W-1:0] tag,
                                                  input logic [IDX_W-1:0] idx,
                                                  input logic [1:0]       w);
    return {tag, idx, w, 1'b0};
  endfunction

endpackage

// File: rtl/cache_rd_pipe.sv
// Tracks outstanding memory reads: a MEM_LAT-deep shift of {valid, word}
// whose tail marks the cycle a read's data is on m_data_out.
module cache_rd_pipe #(
  parameter int MEM_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       issue,
  input  logic [1:0] issue_word,
  output logic       ret_valid,
  output logic [1:0] ret_word
);

  genvar gi;
  generate
    for (gi = 0; gi < MEM_LAT; gi++) begin : g_stage
      logic       v_reg;
      logic [1:0] w_reg;
      logic       v_in;
      logic [1:0] w_in;

      if (gi == 0) begin : g_head
        assign v_in = issue;
        assign w_in = issue_word;
      end else begin : g_link
        assign v_in = g_stage[gi-1].v_reg;
        assign w_in = g_stage[gi-1].w_reg;
      end

      // One pipeline stage; reset drops every in-flight read.
      always_ff @(posedge clk) begin
        if (rst) begin
          v_reg <= 1'b0;
          w_reg <= 2'd0;
        end else begin
          v_reg <= v_in;
          w_reg <= w_in;
        end
      end
    end
  endgenerate

  assign ret_valid = g_stage[MEM_LAT-1].v_reg;
  assign ret_word  = g_stage[MEM_LAT-1].w_reg;

endmodule

// File: rtl/cache_miss_ctrl.sv
// Miss sequencer for a direct-mapped write-back, write-allocate cache:
// hits finish in the request cycle; misses do writeback, fill, then retry.
import cache_ctrl_pkg::*;

module cache_miss_ctrl #(
  parameter int MEM_LAT = 2,
  parameter int FILE_ID = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_rd,
  input  logic              req_wr,
  input  logic [15:0]       addr,
  input  logic [WORD_W-1:0] data_in,
  output logic [WORD_W-1:0] data_out,
  output logic              done,
  output logic              stall,
  output logic              cache_hit,
  output logic              err,
  output logic              c_enable,
  output logic              c_comp,
  output logic              c_write,
  output logic              c_valid_in,
  output logic [TAG_W-1:0]  c_tag_in,
  output logic [IDX_W-1:0]  c_index,
  output logic [OFF_W-1:0]  c_offset,
  output logic [WORD_W-1:0] c_data_in,
  input  logic              c_hit,
  input  logic              c_dirty,
  input  logic              c_valid,
  input  logic [TAG_W-1:0]  c_tag_out,
  input  logic [WORD_W-1:0] c_data_out,
  output logic [4:0]        c_file_id,
  output logic [15:0]       m_addr,
  output logic              m_rd,
  output logic              m_wr,
  output logic [WORD_W-1:0] m_data_in,
  input  logic [WORD_W-1:0] m_data_out,
  input  logic              m_stall
);

  state_t            state_reg, state_next;
  logic              op_wr_reg, op_wr_next;
  logic [TAG_W-1:0]  tag_reg, tag_next;
  logic [TAG_W-1:0]  victim_reg, victim_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [1:0]        off_reg, off_next;
  logic [WORD_W-1:0] data_reg, data_next;
  logic [1:0]        wb_cnt_reg, wb_cnt_next;
  logic [1:0]        iss_cnt_reg, iss_cnt_next;
  logic              iss_done_reg, iss_done_next;
  logic              ret_valid;
  logic [1:0]        ret_word;

  assign c_file_id = 5'(FILE_ID);

  cache_rd_pipe #(.MEM_LAT(MEM_LAT)) u_rd_pipe (
    .clk        (clk),
    .rst        (rst),
    .issue      (m_rd),
    .issue_word (iss_cnt_reg),
    .ret_valid  (ret_valid),
    .ret_word   (ret_word)
  );

  // Next-state and output decode for all four phases of a request.
  always_comb begin
    state_next    = state_reg;
    op_wr_next    = op_wr_reg;
    tag_next      = tag_reg;
    victim_next   = victim_reg;
    idx_next      = idx_reg;
    off_next      = off_reg;
    data_next     = data_reg;
    wb_cnt_next   = wb_cnt_reg;
    iss_cnt_next  = iss_cnt_reg;
    iss_done_next = iss_done_reg;
    data_out      = '0;
    done          = 1'b0;
    stall         = 1'b0;
    cache_hit     = 1'b0;
    err           = 1'b0;
    c_enable      = 1'b0;
    c_comp        = 1'b0;
    c_write       = 1'b0;
    c_valid_in    = 1'b0;
    c_tag_in      = '0;
    c_index       = '0;
    c_offset      = '0;
    c_data_in     = '0;
    m_addr        = '0;
    m_rd          = 1'b0;
    m_wr          = 1'b0;
    m_data_in     = '0;

    case (state_reg)
      IDLE: begin
        if (req_rd && req_wr) begin
          done = 1'b1;
          err  = 1'b1;
        end else if (req_rd || req_wr) begin
          c_enable  = 1'b1;
          c_comp    = 1'b1;
          c_write   = req_wr;
          c_tag_in  = addr[15:11];
          c_index   = addr[10:3];
          c_offset  = addr[2:0] & 3'b110;
          c_data_in = data_in;
          if (c_hit) begin
            done      = 1'b1;
            cache_hit = 1'b1;
            data_out  = c_data_out;
          end else begin
            op_wr_next    = req_wr;
            tag_next      = addr[15:11];
            idx_next      = addr[10:3];
            off_next      = addr[2:1];
            data_next     = data_in;
            victim_next   = c_tag_out;
            wb_cnt_next   = '0;
            iss_cnt_next  = '0;
            iss_done_next = 1'b0;
            state_next    = (c_valid && c_dirty) ? WB : FILL;
          end
        end
      end

      WB: begin
        stall     = 1'b1;
        c_enable  = 1'b1;
        c_index   = idx_reg;
        c_offset  = {wb_cnt_reg, 1'b0};
        m_wr      = 1'b1;
        m_addr    = word_addr(victim_reg, idx_reg, wb_cnt_reg);
        m_data_in = c_data_out;
        if (!m_stall) begin
          if (wb_cnt_reg == 2'd3) begin
            wb_cnt_next = '0;
            state_next  = FILL;
          end else begin
            wb_cnt_next = wb_cnt_reg + 2'd1;
          end
        end
      end

      FILL: begin
        stall = 1'b1;
        if (!iss_done_reg && !m_stall) begin
          m_rd   = 1'b1;
          m_addr = word_addr(tag_reg, idx_reg, iss_cnt_reg);
          if (iss_cnt_reg == 2'd3) iss_done_next = 1'b1;
          else                     iss_cnt_next  = iss_cnt_reg + 2'd1;
        end
        // Words return in issue order, so word 3 landing ends the fill.
        if (ret_valid) begin
          c_enable   = 1'b1;
          c_write    = 1'b1;
          c_valid_in = 1'b1;
          c_tag_in   = tag_reg;
          c_index    = idx_reg;
          c_offset   = {ret_word, 1'b0};
          c_data_in  = m_data_out;
          if (ret_word == 2'd3) state_next = RETRY;
        end
      end

      RETRY: begin
        c_enable      = 1'b1;
        c_comp        = 1'b1;
        c_write       = op_wr_reg;
        c_tag_in      = tag_reg;
        c_index       = idx_reg;
        c_offset      = {off_reg, 1'b0};
        c_data_in     = data_reg;
        done          = 1'b1;
        data_out      = c_data_out;
        iss_cnt_next  = '0;
        iss_done_next = 1'b0;
        state_next    = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  // State and request latches; reset aborts any miss in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      op_wr_reg    <= 1'b0;
      tag_reg      <= '0;
      victim_reg   <= '0;
      idx_reg      <= '0;
      off_reg      <= '0;
      data_reg     <= '0;
      wb_cnt_reg   <= '0;
      iss_cnt_reg  <= '0;
      iss_done_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      op_wr_reg    <= op_wr_next;
      tag_reg      <= tag_next;
      victim_reg   <= victim_next;
      idx_reg      <= idx_next;
      off_reg      <= off_next;
      data_reg     <= data_next;
      wb_cnt_reg   <= wb_cnt_next;
      iss_cnt_reg  <= iss_cnt_next;
      iss_done_reg <= iss_done_next;
    end
  end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Bench for cache_miss_ctrl: models the cache arrays and a fixed-latency
// memory, runs a directed vector table, corner sequences, then random traffic.
module tb_cache_miss_ctrl;

  localparam int MEM_LAT = 2;

  logic        clk = 1'b0;
  logic        rst, req_rd, req_wr, m_stall;
  logic [15:0] addr, data_in, data_out;
  logic        done, stall, cache_hit, err;
  logic        c_enable, c_comp, c_write, c_valid_in;
  logic [4:0]  c_tag_in, c_tag_out, c_file_id;
  logic [7:0]  c_index;
  logic [2:0]  c_offset;
  logic [15:0] c_data_in, c_data_out;
  logic        c_hit, c_dirty, c_valid;
  logic [15:0] m_addr, m_data_in, m_data_out;
  logic        m_rd, m_wr;

  always #5 clk = ~clk;

  cache_miss_ctrl #(.MEM_LAT(MEM_LAT), .FILE_ID(0)) dut (
    .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr), .addr(addr),
    .data_in(data_in), .data_out(data_out), .done(done), .stall(stall),
    .cache_hit(cache_hit), .err(err), .c_enable(c_enable), .c_comp(c_comp),
    .c_write(c_write), .c_valid_in(c_valid_in), .c_tag_in(c_tag_in),
    .c_index(c_index), .c_offset(c_offset), .c_data_in(c_data_in),
    .c_hit(c_hit), .c_dirty(c_dirty), .c_valid(c_valid), .c_tag_out(c_tag_out),
    .c_data_out(c_data_out), .c_file_id(c_file_id), .m_addr(m_addr),
    .m_rd(m_rd), .m_wr(m_wr), .m_data_in(m_data_in), .m_data_out(m_data_out),
    .m_stall(m_stall)
  );

  function automatic logic [15:0] init_pat(input int i);
    return 16'(i * 40503) ^ 16'h3C5A;
  endfunction

  // ---------------- cache array model ----------------
  bit        cv   [256];
  bit        cdty [256];
  bit [4:0]  ct   [256];
  bit [15:0] cd   [1024];

  assign c_valid    = cv[c_index];
  assign c_dirty    = cdty[c_index];
  assign c_tag_out  = ct[c_index];
  assign c_hit      = cv[c_index] && (ct[c_index] == c_tag_in);
  assign c_data_out = cd[{c_index, c_offset[2:1]}];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) cv[i] <= 1'b0;
    end else if (c_enable && c_write) begin
      if (c_comp) begin
        if (c_hit) begin
          cd[{c_index, c_offset[2:1]}] <= c_data_in;
          cdty[c_index] <= 1'b1;
        end
      end else begin
        cd[{c_index, c_offset[2:1]}] <= c_data_in;
        ct[c_index]   <= c_tag_in;
        cv[c_index]   <= c_valid_in;
        cdty[c_index] <= 1'b0;
      end
    end
  end

  // ---------------- main memory model ----------------
  bit [15:0]   mem_arr  [32768];
  bit          mem_seen [32768];
  logic [15:0] rdq [MEM_LAT];
  int          n_rd = 0, n_wr = 0;

  function automatic logic [15:0] mem_val(input int i);
    return mem_seen[i] ? mem_arr[i] : init_pat(i);
  endfunction

  always @(posedge clk) begin
    if (!rst && m_wr && !m_stall) begin
      mem_arr[m_addr[15:1]]  <= m_data_in;
      mem_seen[m_addr[15:1]] <= 1'b1;
    end
    rdq[0] <= mem_val(int'(m_addr[15:1]));
    for (int i = 1; i < MEM_LAT; i++) rdq[i] <= rdq[i-1];
    if (!rst && m_rd && !m_stall) n_rd <= n_rd + 1;
    if (!rst && m_wr && !m_stall) n_wr <= n_wr + 1;
  end
  assign m_data_out = rdq[MEM_LAT-1];

  // ---------------- checking helpers ----------------
  int n_tests = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        hit, er, quiet, stall_ok;
    logic [15:0] dout;
    int          lat, nrd, nwr;
  } res_t;

  task automatic do_req(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [15:0] d, input int st_from, input int st_len,
                        output res_t r);
    int cyc, rd0, wr0;
    bit got;
    @(posedge clk); #1;
    req_rd = rd; req_wr = wr; addr = a; data_in = d;
    rd0 = n_rd; wr0 = n_wr; cyc = 0; got = 0;
    r.hit = 0; r.er = 0; r.quiet = 0; r.stall_ok = 1; r.dout = 0; r.lat = -1;
    while (!got && cyc < 200) begin
      m_stall = (cyc >= st_from) && (cyc < st_from + st_len);
      @(negedge clk);
      if (done) begin
        got = 1; r.hit = cache_hit; r.er = err; r.dout = data_out; r.lat = cyc;
        r.quiet = !(c_enable || m_rd || m_wr);
        if (stall !== 1'b0) r.stall_ok = 0;
      end else if (stall !== (cyc > 0)) begin
        r.stall_ok = 0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    req_rd = 0; req_wr = 0; m_stall = 0;
    r.nrd = n_rd - rd0; r.nwr = n_wr - wr0;
    $display("[TB] req rd=%0b wr=%0b a=%h d=%h -> hit=%0b err=%0b dout=%h lat=%0d rd=%0d wr=%0d",
             rd, wr, a, d, r.hit, r.er, r.dout, r.lat, r.nrd, r.nwr);
  endtask

  typedef struct {
    logic        rd, wr;
    logic [15:0] a, d;
    logic        exp_hit, exp_err, chk_data;
    logic [15:0] exp_data;
    int          exp_lat, exp_nrd, exp_nwr;
  } vec_t;

  // reference model state (architectural memory + which lines are cached)
  logic [15:0] golden [32768];
  bit          rv [256];
  bit          rdty [256];
  bit [4:0]    rt [256];

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1; req_rd = 0; req_wr = 0; m_stall = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
    for (int i = 0; i < 32768; i++) golden[i] = mem_val(i);
    for (int i = 0; i < 256; i++) begin rv[i] = 0; rdty[i] = 0; rt[i] = 0; end
  endtask

  initial begin
    vec_t vt [5];
    res_t r;
    logic [15:0] a, d;
    logic [7:0]  ix;
    logic [4:0]  tg;
    logic        rd, wr, h, dv;
    int          op, e_lat, e_nrd, e_nwr;
    logic [15:0] e_data;

    rst = 1; req_rd = 0; req_wr = 0; addr = 0; data_in = 0; m_stall = 0;

    // directed table: clean miss, hit, store hit, dirty-victim miss, illegal
    vt[0] = '{1, 0, 16'h0010, 16'h0000, 0, 0, 1, init_pat(16'h0008), 5 + MEM_LAT, 4, 0};
    vt[1] = '{1, 0, 16'h0010, 16'h0000, 1, 0, 1, init_pat(16'h0008), 0, 0, 0};
    vt[2] = '{0, 1, 16'h0010, 16'hBEEF, 1, 0, 0, 16'h0000, 0, 0, 0};
    vt[3] = '{1, 0, 16'h8010, 16'h0000, 0, 0, 1, init_pat(16'h4008), 9 + MEM_LAT, 4, 4};
    vt[4] = '{1, 1, 16'h0010, 16'h1234, 0, 1, 0, 16'h0000, 0, 0, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          {16'(data_out), done, stall, cache_hit, err, c_enable, m_rd, m_wr},
          32'd0);
    @(posedge clk); #1;
    rst = 0;

    for (int i = 0; i < 5; i++) begin
      do_req(vt[i].rd, vt[i].wr, vt[i].a, vt[i].d, 999, 0, r);
      check($sformatf("vec%0d_hit", i), 32'(r.hit), 32'(vt[i].exp_hit));
      check($sformatf("vec%0d_err", i), 32'(r.er), 32'(vt[i].exp_err));
      check($sformatf("vec%0d_lat", i), 32'(r.lat), 32'(vt[i].exp_lat));
      check($sformatf("vec%0d_nrd", i), 32'(r.nrd), 32'(vt[i].exp_nrd));
      check($sformatf("vec%0d_nwr", i), 32'(r.nwr), 32'(vt[i].exp_nwr));
      check($sformatf("vec%0d_stall", i), 32'(r.stall_ok), 32'd1);
      if (vt[i].chk_data) check($sformatf("vec%0d_data", i), 32'(r.dout), 32'(vt[i].exp_data));
      if (vt[i].exp_err)  check($sformatf("vec%0d_quiet", i), 32'(r.quiet), 32'd1);
    end
    // the dirty victim went back to memory with the stored word in place
    check("wb_word0", 32'(mem_val(16'h0008)), 32'h0000BEEF);
    check("wb_word3", 32'(mem_val(16'h000B)), 32'(init_pat(16'h000B)));

    // memory stalls for 3 cycles while the fill is issuing
    do_req(1, 0, 16'h0100, 16'h0, 2, 3, r);
    check("stall_lat", 32'(r.lat), 32'(5 + MEM_LAT + 3));
    check("stall_data", 32'(r.dout), 32'(init_pat(16'h0080)));
    check("stall_nrd", 32'(r.nrd), 32'd4);

    // reset in the middle of a fill
    @(posedge clk); #1;
    req_rd = 1; addr = 16'h0200;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1; req_rd = 0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_fill",
          {16'(data_out), done, stall, cache_hit, err, c_enable, m_rd, m_wr},
          32'd0);
    @(posedge clk); #1;
    rst = 0;
    do_req(1, 0, 16'h0200, 16'h0, 999, 0, r);
    check("rst_reread_hit", 32'(r.hit), 32'd0);
    check("rst_reread_lat", 32'(r.lat), 32'(5 + MEM_LAT));
    check("rst_reread_data", 32'(r.dout), 32'(init_pat(16'h0100)));
    do_req(1, 0, 16'h0010, 16'h0, 999, 0, r);
    check("rst_old_line_miss", 32'(r.hit), 32'd0);

    // random traffic on a few conflicting lines against the reference model
    pulse_reset();
    for (int n = 0; n < 80; n++) begin
      op = $urandom_range(0, 15);
      rd = (op <= 8);
      wr = (op == 0) || (op > 8);
      ix = 8'($urandom_range(0, 3));
      op = $urandom_range(0, 3);
      tg = (op == 3) ? 5'd31 : 5'(op);
      a  = {tg, ix, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1))};
      d  = 16'($urandom);

      e_data = golden[a[15:1]];
      e_nrd = 0; e_nwr = 0; e_lat = 0; h = 0;
      if (!(rd && wr)) begin
        h = rv[ix] && (rt[ix] == tg);
        if (!h) begin
          dv    = rv[ix] && rdty[ix];
          e_nwr = dv ? 4 : 0;
          e_nrd = 4;
          e_lat = e_nwr + 4 + MEM_LAT + 1;
          rv[ix] = 1; rt[ix] = tg; rdty[ix] = 0;
        end
        if (wr) begin golden[a[15:1]] = d; rdty[ix] = 1; end
      end

      do_req(rd, wr, a, d, 999, 0, r);
      check($sformatf("rnd%0d_err", n), 32'(r.er), 32'(rd && wr));
      check($sformatf("rnd%0d_hit", n), 32'(r.hit), 32'(h));
      check($sformatf("rnd%0d_lat", n), 32'(r.lat), 32'(e_lat));
      check($sformatf("rnd%0d_nrd", n), 32'(r.nrd), 32'(e_nrd));
      check($sformatf("rnd%0d_nwr", n), 32'(r.nwr), 32'(e_nwr));
      check($sformatf("rnd%0d_stall", n), 32'(r.stall_ok), 32'd1);
      if (rd && !wr) check($sformatf("rnd%0d_data", n), 32'(r.dout), 32'(e_data));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
